// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone B3 classic slave UART transmitter for the SoC console.
// Bus writes queue bytes in a FIFO; the serializer sends them as 8N1 frames, LSB first.
module wb_uart_tx #(
    parameter int DEFAULT_DIV = 87,
    parameter int FIFO_AW     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        uart_tx
);
    // state    | meaning
    // ST_IDLE  | line high, waiting for a queued byte
    // ST_START | start bit (low) for one latched divisor period
    // ST_DATA  | eight data bits, LSB first, r_bit indexes the current bit
    // ST_STOP  | stop bit (high); may chain straight into the next START
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DIV    = 2'd2;

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};

    logic                 r_ack;
    logic [31:0]          r_dat_o;
    logic                 r_tx;
    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_level;
    logic                 r_ovf;
    logic [15:0]          r_div;
    logic [15:0]          r_div_lat;
    logic [15:0]          r_cnt;
    logic [1:0]           r_state;
    logic [2:0]           r_bit;
    logic [7:0]           r_shift;

    logic        w_acc;
    logic        w_wr_data;
    logic        w_wr_stat;
    logic        w_wr_div;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_busy;
    logic        w_cnt_done;
    logic [15:0] w_div_wr;
    logic [15:0] w_div_next;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_acc     = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr_data = w_acc & wb_we_i & (wb_adr_i[3:2] == A_DATA) & wb_sel_i[0];
    assign w_wr_stat = w_acc & wb_we_i & (wb_adr_i[3:2] == A_STATUS) & wb_sel_i[0];
    assign w_wr_div  = w_acc & wb_we_i & (wb_adr_i[3:2] == A_DIV) & (wb_sel_i[0] | wb_sel_i[1]);

    assign w_full     = (r_level == LVL_FULL);
    assign w_empty    = (r_level == '0);
    assign w_push     = w_wr_data & ~w_full;
    assign w_busy     = (r_state != ST_IDLE);
    assign w_cnt_done = (r_cnt == 16'd0);
    assign w_pop      = ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_cnt_done)) & ~w_empty;

    assign w_unused = ^{wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

    always_comb begin
        w_div_wr = r_div;
        if (wb_sel_i[0]) w_div_wr[7:0]  = wb_dat_i[7:0];
        if (wb_sel_i[1]) w_div_wr[15:8] = wb_dat_i[15:8];
        w_div_next = (w_div_wr < 16'd2) ? 16'd2 : w_div_wr;
    end

    always_comb begin
        w_status                 = '0;
        w_status[FIFO_AW+8:8]    = r_level;
        w_status[3]              = r_ovf;
        w_status[2]              = w_empty;
        w_status[1]              = w_full;
        w_status[0]              = w_busy;
    end

    always_comb begin
        w_rdata = '0;
        case (wb_adr_i[3:2])
            A_STATUS: w_rdata = w_status;
            A_DIV:    w_rdata = {16'd0, r_div};
            default:  w_rdata = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ack   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            r_ack   <= w_acc;
            r_dat_o <= (w_acc & ~wb_we_i) ? w_rdata : 32'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div <= 16'(DEFAULT_DIV);
            r_ovf <= 1'b0;
        end else begin
            if (w_wr_div) r_div <= w_div_next;
            if (w_wr_data & w_full)
                r_ovf <= 1'b1;
            else if (w_wr_stat & wb_dat_i[3])
                r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= wb_dat_i[7:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // A pop always restarts a frame, whether from IDLE or from the last STOP cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_tx      <= 1'b1;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_div_lat <= 16'(DEFAULT_DIV);
        end else if (w_pop) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_div_lat <= r_div;
            r_cnt     <= r_div - 16'd1;
            r_bit     <= '0;
            r_tx      <= 1'b0;
            r_state   <= ST_START;
        end else begin
            case (r_state)
                ST_START: begin
                    if (w_cnt_done) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                        r_cnt   <= r_div_lat - 16'd1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (w_cnt_done) begin
                        r_cnt <= r_div_lat - 16'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (w_cnt_done)
                        r_state <= ST_IDLE;
                    else
                        r_cnt <= r_cnt - 16'd1;
                end
                default: begin
                    r_tx <= 1'b1;
                end
            endcase
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat_o;
    assign uart_tx  = r_tx;

endmodule

// File: doc/wb_uart_tx.md
# wb_uart_tx

Wishbone B3 classic slave UART transmitter: the CPU-side register interface and serial output end of the SoC console link. Bytes written by the bus initiator are queued in a FIFO and serialized as 8N1 frames, LSB first, on `uart_tx`. The block sits on the SoC peripheral bus beside the boot ROM and drives the board UART TXD pin. The baud divisor is a run-time register with a parameterized reset value.

## Interface
- `DEFAULT_DIV`, 87: reset value of DIV, in clocks per bit (10 MHz / 115200).
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW = 16 entries.
- `clock` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high reset.
- `wb_adr_i` in 4: byte address; only [3:2] decoded. 0 = DATA, 1 = STATUS, 2 = DIV, 3 = reserved (reads 0, writes ignored).
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte lanes.
- `wb_we_i` in 1: write enable.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_dat_o` out 32: read data, valid while `wb_ack_o` is high.
- `wb_ack_o` out 1: transfer acknowledge.
- `uart_tx` out 1: serial output, idle high.

## Operation
- **Bus handshake:**
  - `wb_ack_o <= wb_cyc_i & wb_stb_i & ~wb_ack_o`.
  - Every access takes exactly 2 cycles; acks are never back-to-back.
  - Writes take effect at the same edge where `wb_ack_o` rises.
- **DATA write** (requires `wb_sel_i[0]`): pushes `wb_dat_i[7:0]`.
  - If the FIFO is full, the byte is dropped and OVF is set.
  - Full is evaluated before any same-cycle pop, so a push while full is dropped even if a pop occurs on that edge.
  - DATA reads return 0.
- **STATUS read:**
  - bit0 BUSY: serializer not IDLE.
  - bit1 FULL.
  - bit2 EMPTY.
  - bit3 OVF, sticky.
  - bits[FIFO_AW+8:8] LEVEL.
  - All other bits 0.
- **STATUS write:** with `wb_sel_i[0]` and `wb_dat_i[3]=1`, clears OVF. A same-cycle overflow is impossible because only one access occurs per cycle.
- **DIV:** 16 bits, read/write.
  - `wb_sel_i[0]` and `wb_sel_i[1]` gate the low and high bytes.
  - Written values below 2 are stored as 2.
  - Reads return the stored value zero-extended.
- **Serializer states:** IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is not empty, pop into the shift register, latch DIV into the bit counter reload, go to START.
  - START: `uart_tx`=0 for DIV cycles, then DATA.
  - DATA: 8 bits LSB first, DIV cycles each; 3-bit index counter; after bit 7, go to STOP.
  - STOP: `uart_tx`=1 for DIV cycles. At the end, if the FIFO is not empty, pop and go directly to START with no idle cycle; otherwise go to IDLE.
  - `uart_tx` is registered.
- A DIV change takes effect at the next frame start only; the in-flight frame keeps its latched divisor.
- Capacity: 16 FIFO entries plus 1 byte in the shift register.

## Timing
- **Reset values:**
  - `uart_tx`=1, `wb_ack_o`=0, `wb_dat_o`=0.
  - FIFO empty, LEVEL=0, OVF=0, DIV=`DEFAULT_DIV`, state IDLE.
- **Reset mid-frame:** `uart_tx` is 1 on the cycle after the reset edge. The frame is truncated and the FIFO is flushed.
- **Write-to-line latency:** ack rises at edge E0 (push). If serializer is IDLE, pop occurs at E1 and `uart_tx` falls at E1, i.e. one clock after the ack rises.
- **Frame length:** exactly 10×DIV clocks. Consecutive frames are contiguous: the last STOP cycle is followed directly by the next START cycle.
- **LEVEL:**
  - Increments on push, decrements on pop, unchanged on simultaneous push and pop.
  - Never wraps: it saturates by construction at 16 (push blocked when full); pop is blocked when empty.
  - FIFO pointers wrap modulo 2^FIFO_AW.
- **Read data:** `wb_dat_o` is registered on the ack edge and is 0 when ack is low.

## Test plan
- **Reset values:** assert reset 2 cycles, then read STATUS and DIV → `uart_tx`=1, STATUS=0x4, DIV=87, ack pulses exactly 1 cycle per access.
- **Single frame:** write DIV=4, then DATA=0x55.
  - Required waveform: `uart_tx` low 1 cycle after ack; then 4-cycle bits 1,0,1,0,1,0,1,0; then stop high.
  - BUSY=1 throughout, 0 after 40 cycles from the start edge.
- **Overflow:** DIV=4, write 18 bytes 0x00..0x11 back-to-back → OVF=1, FULL=1 while queued. Exactly 17 frames 0x00..0x10 appear on `uart_tx`. Write STATUS 0x8 → OVF=0.
- **Contiguous frames:** write 0xFF then 0x00 → the second start bit begins exactly 40 cycles after the first start bit, with no extra idle cycle.
- **DIV change mid-frame:** DIV=4, send 0xA5; during bit 3, write DIV=8 → frame 1 uses 4-cycle bits, the next frame uses 8-cycle bits. Write DIV=1 → DIV reads 2.
- **Reset mid-frame:** reset during DATA bit 2 with 3 bytes queued → `uart_tx`=1 next cycle, LEVEL=0, no further frames.
